// File: rtl/dm_access_ctrl_pkg.sv
// rtl/dm_access_ctrl_pkg.sv - size codes, strobe encodings and FSM states for dm_access_ctrl
package dm_access_ctrl_pkg;

  localparam logic [1:0] DM_SIZE_B = 2'b00;
  localparam logic [1:0] DM_SIZE_H = 2'b01;
  localparam logic [1:0] DM_SIZE_W = 2'b10;

  localparam logic DM_R_ON = 1'b1;
  localparam logic DM_W_ON = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_LD_DONE = 3'd3,
    ST_MERGE   = 3'd4,
    ST_ERR     = 3'd5
  } dm_state_e;

  // Size 11 has no defined width, so it is rejected like a misaligned access.
  function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      DM_SIZE_B: dm_misaligned = 1'b0;
      DM_SIZE_H: dm_misaligned = addr_lo[0];
      DM_SIZE_W: dm_misaligned = (addr_lo != 2'b00);
      default:   dm_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - little-endian lane extraction for loads and lane merge for sub-word stores
module dm_lane_align
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = 8'(word >> {addr_lo, 3'b000});
    half_sel    = 16'(word >> {addr_lo[1], 4'b0000});
    load_data   = word;
    merged_word = store_data;
    case (size)
      DM_SIZE_B: begin
        load_data   = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        merged_word = word;
        merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      end
      DM_SIZE_H: begin
        load_data   = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        merged_word = word;
        merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: begin
        load_data   = word;
        merged_word = store_data;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - MEM-stage load/store FSM driving a word-only data memory
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_r,
  output logic        dm_w,
  input  logic [31:0] dm_rdata
);

  dm_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  dm_lane_align u_align (
    .word        (dm_rdata),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
    end
  end

  // Outputs decode from state_q alone, so an async reset clears them at once.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    we_d       = we_q;
    uns_d      = uns_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    dm_addr    = {addr_q[31:2], 2'b00};
    dm_wdata   = '0;
    dm_r       = 1'b0;
    dm_w       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        dm_addr   = '0;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          if (dm_misaligned(req_size, req_addr[1:0])) begin
            state_d = ST_ERR;
          end else if (req_we && req_size == DM_SIZE_W) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        dm_r    = DM_R_ON;
        state_d = we_q ? ST_MERGE : ST_LD_DONE;
      end
      ST_LD_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = load_data;
        state_d    = ST_IDLE;
      end
      ST_MERGE: begin
        dm_w       = DM_W_ON;
        dm_wdata   = merged_word;
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_WR: begin
        dm_w       = DM_W_ON;
        dm_wdata   = wdata_q;
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
